spi_config_master: RTL and testbench

SPI initiator that loads one configuration word into the FM transmitter's SPI configuration slave and reads back the word it replaces. It sits in a companion controller or on the test harness, driving the slave's `spi_clk`, `spi_csn` and `spi_mosi` and sampling `spi_miso`. It generates a divided SPI clock from the system clock, runs the transfer with a small state machine, and reports completion with a one-cycle pulse.

---
 rtl/fm_cfg_pkg.sv | 28 ++
 rtl/spi_half_period_timer.sv | 30 +++
 rtl/spi_config_master.sv | 160 ++++++++++++++++
 tb/tb_spi_config_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_cfg_pkg.sv
// Shared configuration-word layout for the FM transmitter SPI link.
// Field widths, derived word width and SPI master state encoding.
package fm_cfg_pkg;

    localparam int unsigned CFG_N_W    = 18;
    localparam int unsigned CFG_K_W    = 4;
    localparam int unsigned CFG_L_W    = 2;
    localparam int unsigned CFG_D_W    = 5;
    localparam int unsigned CFG_FLAG_W = 3;
    localparam int unsigned CFG_OVR_W  = 4;

    // Master and slave both size their shift registers from this
    localparam int unsigned CFG_DW = CFG_N_W + CFG_K_W + CFG_L_W + CFG_D_W
                                   + CFG_FLAG_W + CFG_OVR_W;

    // Half-period timer width; covers CLK_DIV up to 255
    localparam int unsigned TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// Down-counter timing one SPI half-period of CLK_DIV system clocks.
// Reloaded on every state change; expire flags the transition cycle.
module spi_half_period_timer
    import fm_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_expire_c
);

    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(CLK_DIV - 1);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TMR_W'(1);
        end
    end

    assign o_expire_c = (r_cnt == '0);

endmodule

// File: rtl/spi_config_master.sv
// Mode-0 SPI initiator: shifts one config word into the slave and
// captures the word it displaces. All SPI pins come straight from flops.
module spi_config_master
    import fm_cfg_pkg::*;
#(
    parameter int unsigned DW      = CFG_DW,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
);

    localparam int unsigned CW = $clog2(DW + 1);

    spi_state_e      r_state;
    spi_state_e      w_state_nxt;
    logic [DW-2:0]   r_tx;
    logic [DW-2:0]   w_tx_nxt;
    logic [DW-1:0]   r_rx;
    logic [DW-1:0]   w_rx_nxt;
    logic [CW-1:0]   r_bit_cnt;
    logic [CW-1:0]   w_bit_cnt_nxt;
    logic [CW-1:0]   w_bit_inc;
    logic [DW-1:0]   r_rd;
    logic [DW-1:0]   w_rd_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_sclk;
    logic            w_sclk_nxt;
    logic            r_csn;
    logic            w_csn_nxt;
    logic            r_mosi;
    logic            w_mosi_nxt;
    logic            w_load;
    logic            w_expire;

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .o_expire_c (w_expire)
    );

    assign w_load    = (w_state_nxt != r_state);
    assign w_bit_inc = r_bit_cnt + CW'(1);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_rd      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_csn     <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rd      <= w_rd_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_sclk    <= w_sclk_nxt;
            r_csn     <= w_csn_nxt;
            r_mosi    <= w_mosi_nxt;
        end
    end

    // Next-state and next-output logic; transitions only on timer expiry
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rd_nxt      = r_rd;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_sclk_nxt    = r_sclk;
        w_csn_nxt     = r_csn;
        w_mosi_nxt    = r_mosi;

        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped
                if (start && !r_done) begin
                    w_tx_nxt      = wr_data[DW-2:0];
                    w_mosi_nxt    = wr_data[DW-1];
                    w_bit_cnt_nxt = '0;
                    w_csn_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (w_expire) begin
                    w_sclk_nxt  = 1'b1;
                    w_rx_nxt    = {r_rx[DW-2:0], spi_miso};
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_expire) begin
                    w_sclk_nxt    = 1'b0;
                    w_bit_cnt_nxt = w_bit_inc;
                    if (w_bit_inc < CW'(DW)) begin
                        w_mosi_nxt  = r_tx[DW-2];
                        w_tx_nxt    = {r_tx[DW-3:0], 1'b0};
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_expire) begin
                    w_csn_nxt   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_expire) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_rd_nxt    = r_rx;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd;
    assign spi_clk  = r_sclk;
    assign spi_csn  = r_csn;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: behavioural mode-0 slaves on a CLK_DIV=4 and a
// CLK_DIV=1 instance; expected slave/readback words flow through a scoreboard.
module tb_spi_config_master;

    localparam int unsigned DW = 36;

    typedef struct {
        logic [DW-1:0] wr;
        logic [DW-1:0] rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;

    logic          start = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          busy, done, spi_clk, spi_csn, spi_mosi, spi_miso;
    logic [DW-1:0] rd_data;

    logic          start_f = 1'b0;
    logic [DW-1:0] wr_data_f = '0;
    logic          busy_f, done_f, spi_clk_f, spi_csn_f, spi_mosi_f, spi_miso_f;
    logic [DW-1:0] rd_data_f;

    logic [DW-1:0] s_reg = '0;
    logic          s_cap = 1'b0;
    int            rise_cnt = 0;
    logic [DW-1:0] s_reg_f = '0;
    logic          s_cap_f = 1'b0;
    int            rise_cnt_f = 0;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_config_master #(.DW(DW), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr_data(wr_data),
        .busy(busy), .done(done), .rd_data(rd_data),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_config_master #(.DW(DW), .CLK_DIV(1)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .start(start_f), .wr_data(wr_data_f),
        .busy(busy_f), .done(done_f), .rd_data(rd_data_f),
        .spi_clk(spi_clk_f), .spi_csn(spi_csn_f), .spi_mosi(spi_mosi_f), .spi_miso(spi_miso_f)
    );

    // Mode-0 slaves: sample MOSI on rise, shift and present next MISO on fall
    assign spi_miso   = s_reg[DW-1];
    assign spi_miso_f = s_reg_f[DW-1];

    always @(posedge spi_clk) if (!spi_csn) begin
        s_cap    <= spi_mosi;
        rise_cnt <= rise_cnt + 1;
    end
    always @(negedge spi_clk) if (!spi_csn) s_reg <= {s_reg[DW-2:0], s_cap};

    always @(posedge spi_clk_f) if (!spi_csn_f) begin
        s_cap_f    <= spi_mosi_f;
        rise_cnt_f <= rise_cnt_f + 1;
    end
    always @(negedge spi_clk_f) if (!spi_csn_f) s_reg_f <= {s_reg_f[DW-2:0], s_cap_f};

    task automatic drive_start(input bit fast, input logic s, input logic [DW-1:0] w);
        if (fast) begin
            start_f = s;
            if (s) wr_data_f = w;
        end else begin
            start = s;
            if (s) wr_data = w;
        end
    endtask

    // One full transfer; edge 0 is the edge after which start is raised
    task automatic xfer(input logic [DW-1:0] w, input bit fast, input int poke_at,
                        input bit poke_done, input string tag);
        int c, t_lo, t_rise, t_hi, t_relo, t_done, n_done, r0, n_rise;
        logic w_csn, w_sclk, w_done, w_busy;
        logic [DW-1:0] w_rd, w_slave;
        exp_t ex;
        c = fast ? 1 : 4;
        t_lo = -1; t_rise = -1; t_hi = -1; t_relo = -1; t_done = -1; n_done = 0;
        @(posedge clk); #1;
        ex.wr = w;
        ex.rd = fast ? s_reg_f : s_reg;
        sb_q.push_back(ex);
        r0 = fast ? rise_cnt_f : rise_cnt;
        drive_start(fast, 1'b1, w);
        for (int i = 1; i <= 80 * c; i++) begin
            @(posedge clk); #1;
            drive_start(fast, 1'b0, w);
            if (i == poke_at) drive_start(fast, 1'b1, 36'h0_0000_0001);
            w_csn  = fast ? spi_csn_f : spi_csn;
            w_sclk = fast ? spi_clk_f : spi_clk;
            w_done = fast ? done_f : done;
            w_busy = fast ? busy_f : busy;
            w_rd   = fast ? rd_data_f : rd_data;
            if (i == 1) begin
                checks++;
                if (w_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_accept: got %b expected 1", tag, w_busy);
                end
            end
            if (t_lo < 0 && w_csn === 1'b0) t_lo = i;
            if (t_lo >= 0 && t_hi < 0 && w_csn === 1'b1) t_hi = i;
            if (t_hi >= 0 && t_relo < 0 && w_csn === 1'b0) t_relo = i;
            if (t_rise < 0 && w_sclk === 1'b1) t_rise = i;
            if (w_done === 1'b1) begin
                n_done++;
                if (t_done < 0) begin
                    t_done = i;
                    checks++;
                    if (w_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s busy_at_done: got %b expected 0", tag, w_busy);
                    end
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s scoreboard: done with no expected entry", tag);
                    end else begin
                        ex = sb_q.pop_front();
                        if (w_rd !== ex.rd) begin
                            errors++;
                            $display("FAIL %s rd_data: got %h expected %h", tag, w_rd, ex.rd);
                        end
                    end
                    if (poke_done) drive_start(fast, 1'b1, 36'hA_BCDE_F012);
                end
            end
        end
        n_rise  = (fast ? rise_cnt_f : rise_cnt) - r0;
        w_slave = fast ? s_reg_f : s_reg;
        checks++;
        if (t_lo != 1) begin
            errors++; $display("FAIL %s csn_fall_edge: got %0d expected 1", tag, t_lo);
        end
        checks++;
        if (t_rise != 1 + c) begin
            errors++; $display("FAIL %s first_rise_edge: got %0d expected %0d", tag, t_rise, 1 + c);
        end
        checks++;
        if (t_hi != 1 + 73 * c) begin
            errors++; $display("FAIL %s csn_rise_edge: got %0d expected %0d", tag, t_hi, 1 + 73 * c);
        end
        checks++;
        if (t_done != 1 + 74 * c) begin
            errors++; $display("FAIL %s done_edge: got %0d expected %0d", tag, t_done, 1 + 74 * c);
        end
        checks++;
        if (n_done != 1) begin
            errors++; $display("FAIL %s done_cycles: got %0d expected 1", tag, n_done);
        end
        checks++;
        if (n_rise != DW) begin
            errors++; $display("FAIL %s sclk_rises: got %0d expected %0d", tag, n_rise, DW);
        end
        checks++;
        if (w_slave !== ex.wr) begin
            errors++; $display("FAIL %s slave_word: got %h expected %h", tag, w_slave, ex.wr);
        end
        if (poke_done) begin
            checks++;
            if (t_relo != -1) begin
                errors++; $display("FAIL %s start_on_done_accepted: csn fell at %0d expected never", tag, t_relo);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL reset spi_csn: got %b expected 1", spi_csn); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset spi_clk: got %b expected 0", spi_clk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset spi_mosi: got %b expected 0", spi_mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset rd_data: got %h expected 0", rd_data); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_write;
        xfer(36'h9_A5A5_A5A5, 1'b0, -1, 1'b0, "single");
        checks++;
        if (s_reg !== 36'h9_A5A5_A5A5) begin
            errors++; $display("FAIL single slave_const: got %h expected 9a5a5a5a5", s_reg);
        end
    endtask

    task automatic test_readback;
        xfer(36'h1_2345_6789, 1'b0, -1, 1'b0, "rb_first");
        xfer(36'hF_0000_000F, 1'b0, -1, 1'b0, "rb_second");
        checks++;
        if (rd_data !== 36'h1_2345_6789) begin
            errors++; $display("FAIL readback rd_const: got %h expected 123456789", rd_data);
        end
        checks++;
        if (s_reg !== 36'hF_0000_000F) begin
            errors++; $display("FAIL readback slave_const: got %h expected f0000000f", s_reg);
        end
    endtask

    task automatic test_busy_reject;
        xfer(36'hC_3C3C_3C3C, 1'b0, 50, 1'b0, "busy_reject");
    endtask

    task automatic test_start_on_done;
        xfer(36'h6_1234_ABCD, 1'b0, -1, 1'b1, "start_on_done");
    endtask

    task automatic test_reset_mid;
        int r0, n_done;
        bit hit;
        hit = 1'b0;
        n_done = 0;
        @(posedge clk); #1;
        r0 = rise_cnt;
        drive_start(1'b0, 1'b1, 36'h3_CAFE_F00D);
        for (int i = 1; i <= 200 && !hit; i++) begin
            @(posedge clk); #1;
            drive_start(1'b0, 1'b0, '0);
            if (rise_cnt - r0 >= 10 && spi_clk === 1'b0) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL reset_mid wait_10_rises: got %0d rises expected 10", rise_cnt - r0);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL reset_mid spi_csn: got %b expected 1", spi_csn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_mid spi_clk: got %b expected 0", spi_clk); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_mid rd_data: got %h expected 0", rd_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++; $display("FAIL reset_mid spurious_done: got %0d expected 0", n_done);
        end
        xfer(36'h5_5555_5555, 1'b0, -1, 1'b0, "after_reset");
        checks++;
        if (s_reg !== 36'h5_5555_5555) begin
            errors++; $display("FAIL after_reset slave_const: got %h expected 555555555", s_reg);
        end
    endtask

    task automatic test_clk_div1;
        xfer(36'h9_A5A5_A5A5, 1'b1, -1, 1'b0, "div1_first");
        xfer(36'h2_468A_CE13, 1'b1, -1, 1'b0, "div1_second");
        checks++;
        if (rd_data_f !== 36'h9_A5A5_A5A5) begin
            errors++; $display("FAIL div1 rd_const: got %h expected 9a5a5a5a5", rd_data_f);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_readback;
        test_busy_reject;
        test_start_on_done;
        test_reset_mid;
        test_clk_div1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
